// File: rtl/uart_crypt_tx.sv
// uart_crypt_tx: 8N1 UART transmitter with an optional 8-bit LFSR keystream XOR.
// Ports:
//   M_CLOCK     system clock, rising edge
//   M_RESET_N   asynchronous active-low reset
//   tx_start    send request, sampled in IDLE only
//   tx_data     payload byte, captured on the accepting cycle
//   enc_en      1 = send tx_data^key and advance key after the frame
//   key_resync  reload key with LFSR_SEED, honoured in IDLE only
//   tx_busy     high from the accepting cycle until the frame completes
//   tx_done     one-cycle pulse at frame completion
//   key_out     current key register
//   TX_OUT      serial line, idle high
module uart_crypt_tx #(
   parameter int unsigned CLKS_PER_BIT = 5208,
   parameter int unsigned STOP_BITS    = 1,
   parameter logic [7:0]  LFSR_SEED    = 8'hFF
) (
   input  logic       M_CLOCK,
   input  logic       M_RESET_N,
   input  logic       tx_start,
   input  logic [7:0] tx_data,
   input  logic       enc_en,
   input  logic       key_resync,
   output logic       tx_busy,
   output logic       tx_done,
   output logic [7:0] key_out,
   output logic       TX_OUT
);

   localparam int unsigned TIMER_W = 32;
   localparam int unsigned IDX_W   = 3;
   localparam logic [TIMER_W-1:0] BIT_LAST  = TIMER_W'(CLKS_PER_BIT - 1);
   localparam logic [IDX_W-1:0]   DATA_LAST = IDX_W'(7);
   localparam logic [IDX_W-1:0]   STOP_LAST = IDX_W'(STOP_BITS - 1);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_START = 2'd1,
      ST_DATA  = 2'd2,
      ST_STOP  = 2'd3
   } state_t;

   state_t             state;
   state_t             state_nxt;
   logic [TIMER_W-1:0] bit_timer;
   logic [IDX_W-1:0]   idx;
   logic [7:0]         shreg;
   logic [7:0]         key;
   logic               enc_flag;

   logic               accept_c;
   logic               bit_end_c;
   logic               frame_end_c;
   logic               tx_nxt_c;
   logic [7:0]         key_src_c;

   // One keystream step: Galois-style taps at bits 3 and 4, feedback from bit 7
   function automatic logic [7:0] lfsr_step(input logic [7:0] k);
      logic fb;
      fb = k[7];
      return {k[6], k[5], k[4], k[3] ^ fb, k[2] ^ fb, k[1], k[0], fb};
   endfunction

   // State register
   always_ff @(posedge M_CLOCK or negedge M_RESET_N) begin
      if (!M_RESET_N) state <= ST_IDLE;
      else            state <= state_nxt;
   end

   // Next state and per-cycle control; line level is derived from the current state
   always_comb begin
      state_nxt   = state;
      accept_c    = 1'b0;
      frame_end_c = 1'b0;
      tx_nxt_c    = 1'b1;
      bit_end_c   = (bit_timer == BIT_LAST);
      case (state)
         ST_IDLE: begin
            if (tx_start) begin
               accept_c  = 1'b1;
               state_nxt = ST_START;
            end
         end
         ST_START: begin
            tx_nxt_c = 1'b0;
            if (bit_end_c) state_nxt = ST_DATA;
         end
         ST_DATA: begin
            tx_nxt_c = shreg[idx];
            if (bit_end_c && idx == DATA_LAST) state_nxt = ST_STOP;
         end
         ST_STOP: begin
            if (bit_end_c && idx == STOP_LAST) begin
               frame_end_c = 1'b1;
               state_nxt   = ST_IDLE;
            end
         end
         default: state_nxt = ST_IDLE;
      endcase
   end

   // A resync coinciding with the accepting cycle encrypts with the seed
   always_comb begin
      key_src_c = key_resync ? LFSR_SEED : key;
   end

   // Datapath: bit timer, bit index, payload, key and registered outputs
   always_ff @(posedge M_CLOCK or negedge M_RESET_N) begin
      if (!M_RESET_N) begin
         bit_timer <= '0;
         idx       <= '0;
         shreg     <= '0;
         key       <= LFSR_SEED;
         enc_flag  <= 1'b0;
         tx_busy   <= 1'b0;
         tx_done   <= 1'b0;
         TX_OUT    <= 1'b1;
      end else begin
         tx_done <= frame_end_c;
         TX_OUT  <= tx_nxt_c;

         if (state == ST_IDLE || bit_end_c) bit_timer <= '0;
         else                               bit_timer <= bit_timer + TIMER_W'(1);

         // idx walks data bits in DATA and stop periods in STOP
         if (state == ST_IDLE) begin
            idx <= '0;
         end else if (bit_end_c) begin
            if (state == ST_DATA && idx == DATA_LAST) idx <= '0;
            else if (state != ST_START)              idx <= idx + IDX_W'(1);
         end

         if (accept_c) begin
            shreg    <= enc_en ? (tx_data ^ key_src_c) : tx_data;
            enc_flag <= enc_en;
            tx_busy  <= 1'b1;
         end else if (frame_end_c) begin
            tx_busy  <= 1'b0;
         end

         if (state == ST_IDLE && key_resync) key <= LFSR_SEED;
         else if (frame_end_c && enc_flag)  key <= lfsr_step(key);
      end
   end

   assign key_out = key;

endmodule

// File: tb/tb_uart_crypt_tx.sv
// tb_uart_crypt_tx: directed bench for uart_crypt_tx with CLKS_PER_BIT=16, STOP_BITS=1.
module tb_uart_crypt_tx;

   localparam int unsigned CPB   = 16;
   localparam int unsigned FRAME = 10 * CPB;

   logic       M_CLOCK = 1'b0;
   logic       M_RESET_N;
   logic       tx_start;
   logic [7:0] tx_data;
   logic       enc_en;
   logic       key_resync;
   logic       tx_busy;
   logic       tx_done;
   logic [7:0] key_out;
   logic       TX_OUT;

   int n_checks = 0;
   int n_fails  = 0;

   uart_crypt_tx #(
      .CLKS_PER_BIT(CPB),
      .STOP_BITS   (1),
      .LFSR_SEED   (8'hFF)
   ) dut (
      .M_CLOCK   (M_CLOCK),
      .M_RESET_N (M_RESET_N),
      .tx_start  (tx_start),
      .tx_data   (tx_data),
      .enc_en    (enc_en),
      .key_resync(key_resync),
      .tx_busy   (tx_busy),
      .tx_done   (tx_done),
      .key_out   (key_out),
      .TX_OUT    (TX_OUT)
   );

   always #5 M_CLOCK = ~M_CLOCK;

   task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fails++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // Launch one frame and check every line cycle, busy/done timing and the done count.
   // At cycles poke1/poke2 of the frame, tx_start, key_resync, tx_data and enc_en are
   // disturbed for one cycle; the frame in flight must not change.
   task automatic send_frame(input string tag, input logic [7:0] data, input logic enc,
                             input logic resync_now, input logic [7:0] exp_payload,
                             input int poke1, input int poke2);
      logic [9:0] exp_line;
      logic [9:0] got_line;
      int         level_errs;
      int         done_cnt;
      bit         poke;
      exp_line   = {1'b1, exp_payload, 1'b0};
      got_line   = '0;
      level_errs = 0;
      done_cnt   = 0;
      tx_data    = data;
      enc_en     = enc;
      key_resync = resync_now;
      tx_start   = 1'b1;
      @(posedge M_CLOCK);
      #1;
      tx_start   = 1'b0;
      key_resync = 1'b0;
      check_val({tag, " busy_at_accept"}, 32'(tx_busy), 32'd1);
      for (int c = 1; c <= FRAME + 1; c++) begin
         @(posedge M_CLOCK);
         #1;
         if (c <= FRAME) begin
            if (TX_OUT !== exp_line[(c - 1) / CPB]) level_errs++;
            if ((c - 1) % CPB == CPB / 2) got_line[(c - 1) / CPB] = TX_OUT;
         end
         if (tx_done === 1'b1) done_cnt++;
         if (c == FRAME - 1) check_val({tag, " busy_before_end"}, 32'(tx_busy), 32'd1);
         if (c == FRAME) begin
            check_val({tag, " done_at_end"}, 32'(tx_done), 32'd1);
            check_val({tag, " busy_at_end"}, 32'(tx_busy), 32'd0);
         end
         poke       = (c == poke1) || (c == poke2);
         tx_start   = poke;
         key_resync = poke;
         tx_data    = poke ? ~data : data;
         enc_en     = poke ? ~enc : enc;
      end
      tx_start   = 1'b0;
      key_resync = 1'b0;
      check_val({tag, " line_bits"}, 32'(got_line), 32'(exp_line));
      check_val({tag, " level_errs"}, 32'(level_errs), 32'd0);
      check_val({tag, " done_count"}, 32'(done_cnt), 32'd1);
   endtask

   initial begin
      int toggles;
      int busy_cnt;
      int done_cnt;
      logic prev;

      M_RESET_N  = 1'b0;
      tx_start   = 1'b0;
      tx_data    = 8'h00;
      enc_en     = 1'b0;
      key_resync = 1'b0;

      // 1. reset and idle quiet period
      repeat (5) @(posedge M_CLOCK);
      #1;
      M_RESET_N = 1'b1;
      check_val("rst tx_out", 32'(TX_OUT), 32'd1);
      check_val("rst busy", 32'(tx_busy), 32'd0);
      check_val("rst done", 32'(tx_done), 32'd0);
      check_val("rst key", 32'(key_out), 32'hFF);
      toggles  = 0;
      busy_cnt = 0;
      prev     = TX_OUT;
      for (int i = 0; i < 500; i++) begin
         @(posedge M_CLOCK);
         #1;
         if (TX_OUT !== prev) toggles++;
         if (tx_busy !== 1'b0 || tx_done !== 1'b0) busy_cnt++;
         prev = TX_OUT;
      end
      check_val("idle toggles", 32'(toggles), 32'd0);
      check_val("idle busy", 32'(busy_cnt), 32'd0);

      // 2. plaintext frame
      send_frame("plainA5", 8'hA5, 1'b0, 1'b0, 8'hA5, -1, -1);
      check_val("plainA5 key", 32'(key_out), 32'hFF);

      // 3. two encrypted frames of 3C
      send_frame("enc1", 8'h3C, 1'b1, 1'b0, 8'hC3, -1, -1);
      check_val("enc1 key", 32'(key_out), 32'hE7);
      send_frame("enc2", 8'h3C, 1'b1, 1'b0, 8'hDB, -1, -1);
      check_val("enc2 key", 32'(key_out), 32'hD7);

      // 4. mid-frame disturbances ignored (includes enc_en and resync)
      send_frame("ignore", 8'h00, 1'b0, 1'b0, 8'h00, 40, 100);
      check_val("ignore key", 32'(key_out), 32'hD7);

      // 5. more encrypted frames, idle resync, mid-frame resync, resync with start
      send_frame("enc3", 8'h3C, 1'b1, 1'b0, 8'hEB, -1, -1);
      check_val("enc3 key", 32'(key_out), 32'hB7);
      send_frame("enc4", 8'h3C, 1'b1, 1'b0, 8'h8B, -1, -1);
      check_val("enc4 key", 32'(key_out), 32'h77);
      key_resync = 1'b1;
      @(posedge M_CLOCK);
      #1;
      key_resync = 1'b0;
      check_val("resync key", 32'(key_out), 32'hFF);
      send_frame("enc5", 8'h3C, 1'b1, 1'b0, 8'hC3, 70, -1);
      check_val("enc5 key", 32'(key_out), 32'hE7);
      send_frame("enc6", 8'h3C, 1'b1, 1'b1, 8'hC3, -1, -1);
      check_val("enc6 key", 32'(key_out), 32'hE7);

      // 6. reset during a frame at cycle 70 (payload bit 3 of F7 is low)
      tx_data  = 8'hF7;
      enc_en   = 1'b1;
      tx_start = 1'b1;
      @(posedge M_CLOCK);
      #1;
      tx_start = 1'b0;
      for (int c = 1; c <= 70; c++) begin
         @(posedge M_CLOCK);
         #1;
      end
      check_val("abort pre line", 32'(TX_OUT), 32'd0);
      M_RESET_N = 1'b0;
      #1;
      check_val("abort tx_out", 32'(TX_OUT), 32'd1);
      check_val("abort busy", 32'(tx_busy), 32'd0);
      check_val("abort key", 32'(key_out), 32'hFF);
      done_cnt = 0;
      for (int i = 0; i < 3; i++) begin
         @(posedge M_CLOCK);
         #1;
         if (tx_done !== 1'b0) done_cnt++;
      end
      M_RESET_N = 1'b1;
      for (int i = 0; i < 200; i++) begin
         @(posedge M_CLOCK);
         #1;
         if (tx_done !== 1'b0) done_cnt++;
      end
      check_val("abort no_done", 32'(done_cnt), 32'd0);
      check_val("abort idle line", 32'(TX_OUT), 32'd1);
      send_frame("after_rst", 8'h5A, 1'b0, 1'b0, 8'h5A, -1, -1);
      send_frame("after_rst_enc", 8'h3C, 1'b1, 1'b0, 8'hC3, -1, -1);
      check_val("after_rst key", 32'(key_out), 32'hE7);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
      $finish;
   end

endmodule
